// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_arb_pkg
// Brief  : Shared state encoding and round-robin pointer helper for arbiters.
// Rev    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    localparam logic ST_ARB  = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    // Explicit wrap so non-power-of-2 requester counts never index past n-1.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : fifo_arb_rr_pick
// Brief  : Combinational rotating priority encoder; first set request at or
//          after ptr, wrapping modulo N.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    logic [IDX_W-1:0] w_pos;

    // Scan from the farthest offset down so the nearest hit overwrites last.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        w_pos  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_pos = IDX_W'((int'(ptr) + i) % N);
            if (req[w_pos]) begin
                found         = 1'b1;
                idx           = w_pos;
                onehot        = '0;
                onehot[w_pos] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fifo_wr_arbiter
// Brief  : Round-robin arbiter sharing one fifo write port among NREQ
//          valid/ready producers, zero-latency data mux.
// Config : FIFO_WR_ARBITER_LOCK_EN enables burst lock of up to MAX_BURST words.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 7,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ*WIDTH-1:0]   req_data_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [DEPTH-1:0]        fifo_size_i,
    output logic [WIDTH-1:0]        fifo_data_o,
    output logic                    fifo_set_o,
    output logic [NREQ-1:0]         grant_o,
    output logic                    busy_o
);

    localparam int               c_ptr_w = $clog2(NREQ);
    localparam logic [DEPTH-1:0] c_full  = DEPTH'(DEPTH);

    if (NREQ < 2 || MAX_BURST < 1) begin : g_param_check
        $error("fifo_wr_arbiter: NREQ must be >= 2 and MAX_BURST >= 1");
    end

    // Reads are invisible here, so size == DEPTH is treated as full.
    logic               w_space;
    logic [c_ptr_w-1:0] r_rr_ptr;
    logic               w_found;
    logic [c_ptr_w-1:0] w_idx;
    logic [NREQ-1:0]    w_onehot;
    logic [NREQ-1:0]    w_grant;
    logic [NREQ-1:0]    w_ready;
    logic [WIDTH-1:0]   w_data;

    assign w_space = (fifo_size_i < c_full);

    fifo_arb_rr_pick #(
        .N     (NREQ),
        .IDX_W (c_ptr_w)
    ) u_pick (
        .req    (req_valid_i),
        .ptr    (r_rr_ptr),
        .found  (w_found),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

`ifdef FIFO_WR_ARBITER_LOCK_EN
    localparam int                 c_cnt_w      = $clog2(MAX_BURST + 1);
    localparam logic [c_cnt_w-1:0] c_burst_last = c_cnt_w'(MAX_BURST);

    logic               r_st;
    logic [c_ptr_w-1:0] r_owner;
    logic [c_cnt_w-1:0] r_cnt;
    logic [NREQ-1:0]    w_owner_oh;

    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

    always_comb begin
        w_grant = '0;
        w_ready = '0;
        if (!rst_i) begin
            if (r_st == ST_LOCK) begin
                w_grant = w_owner_oh;
                if (req_valid_i[r_owner] && w_space) begin
                    w_ready = w_owner_oh;
                end
            end else if (w_found && w_space) begin
                w_grant = w_onehot;
                w_ready = w_onehot;
            end
        end
    end

    // The arbitration write counts as the first word of the burst.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_st     <= ST_ARB;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
        end else if (r_st == ST_ARB) begin
            if (w_found && w_space) begin
                r_rr_ptr <= c_ptr_w'(rr_next(int'(w_idx), NREQ));
                if (MAX_BURST > 1) begin
                    r_st    <= ST_LOCK;
                    r_owner <= w_idx;
                    r_cnt   <= c_cnt_w'(1);
                end
            end
        end else if (!req_valid_i[r_owner]) begin
            r_st  <= ST_ARB;
            r_cnt <= '0;
        end else if (w_space) begin
            if (r_cnt + 1'b1 == c_burst_last) begin
                r_st  <= ST_ARB;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign busy_o = !rst_i && (r_st == ST_LOCK);
`else
    always_comb begin
        w_grant = '0;
        w_ready = '0;
        if (!rst_i && w_found && w_space) begin
            w_grant = w_onehot;
            w_ready = w_onehot;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
        end else if (w_found && w_space) begin
            r_rr_ptr <= c_ptr_w'(rr_next(int'(w_idx), NREQ));
        end
    end

    assign busy_o = 1'b0;
`endif

    // OR-mux over the one-hot ready vector yields zero when idle.
    always_comb begin
        w_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_ready[k]) begin
                w_data = w_data | req_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready_o = w_ready;
    assign grant_o     = w_grant;
    assign fifo_set_o  = |w_ready;
    assign fifo_data_o = w_data;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_wr_arbiter
// Brief  : Directed and random stimulus for fifo_wr_arbiter against a
//          behavioural reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 3;
    localparam int WIDTH     = 8;
    localparam int DEPTH     = 7;
    localparam int MAX_BURST = 4;
`ifdef FIFO_WR_ARBITER_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       valid = '0;
    logic [NREQ*WIDTH-1:0] data = '0;
    logic [DEPTH-1:0]      size = '0;
    logic [NREQ-1:0]       req_ready_o;
    logic [WIDTH-1:0]      fifo_data_o;
    logic                  fifo_set_o;
    logic [NREQ-1:0]       grant_o;
    logic                  busy_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit m_lock;
    int m_ptr, m_owner, m_cnt;
    // Model outputs for the current cycle
    logic [NREQ-1:0]  e_ready, e_grant;
    logic [WIDTH-1:0] e_data;
    logic             e_set, e_busy;
    int               e_k;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (valid),
        .req_data_i  (data),
        .req_ready_o (req_ready_o),
        .fifo_size_i (size),
        .fifo_data_o (fifo_data_o),
        .fifo_set_o  (fifo_set_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    task automatic model_eval();
        int k;
        e_ready = '0; e_grant = '0; e_data = '0; e_busy = 1'b0; e_k = -1;
        if (!rst) begin
            if (m_lock) begin
                e_busy           = 1'b1;
                e_grant[m_owner] = 1'b1;
                if (valid[m_owner] && size < DEPTH) e_k = m_owner;
            end else begin
                for (int off = 0; off < NREQ; off++) begin
                    k = (m_ptr + off) % NREQ;
                    if (e_k < 0 && valid[k]) e_k = k;
                end
                if (size >= DEPTH) e_k = -1;
                if (e_k >= 0) e_grant[e_k] = 1'b1;
            end
            if (e_k >= 0) begin
                e_ready[e_k] = 1'b1;
                e_data       = data[e_k*WIDTH +: WIDTH];
            end
        end
        e_set = (e_k >= 0);
    endtask

    task automatic model_step();
        if (rst) begin
            m_lock = 1'b0; m_ptr = 0; m_owner = 0; m_cnt = 0;
        end else if (m_lock) begin
            if (!valid[m_owner]) begin
                m_lock = 1'b0; m_cnt = 0;
            end else if (size < DEPTH) begin
                m_cnt++;
                if (m_cnt == MAX_BURST) begin
                    m_lock = 1'b0; m_cnt = 0;
                end
            end
        end else if (e_k >= 0) begin
            m_ptr = (e_k + 1) % NREQ;
            if (LOCK_EN && MAX_BURST > 1) begin
                m_lock = 1'b1; m_owner = e_k; m_cnt = 1;
            end
        end
    endtask

    task automatic probe(input string tag);
        #1;
        model_eval();
        n_cmp += 5;
        assert (req_ready_o === e_ready) else begin
            n_err++; $error("FAIL %s ready got=%b exp=%b", tag, req_ready_o, e_ready);
        end
        assert (grant_o === e_grant) else begin
            n_err++; $error("FAIL %s grant got=%b exp=%b", tag, grant_o, e_grant);
        end
        assert (fifo_set_o === e_set) else begin
            n_err++; $error("FAIL %s set got=%b exp=%b", tag, fifo_set_o, e_set);
        end
        assert (fifo_data_o === e_data) else begin
            n_err++; $error("FAIL %s data got=%h exp=%h", tag, fifo_data_o, e_data);
        end
        assert (busy_o === e_busy) else begin
            n_err++; $error("FAIL %s busy got=%b exp=%b", tag, busy_o, e_busy);
        end
    endtask

    task automatic expect_val(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++; $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        probe(tag);
        adv();
    endtask

    initial begin
        m_lock = 1'b0; m_ptr = 0; m_owner = 0; m_cnt = 0;
        @(negedge clk);

        // Reset: all handshake outputs low
        rst = 1'b1; valid = '1; data = 24'h332211;
        step("reset0");
        probe("reset1");
        expect_val("reset_set",   8'(fifo_set_o),  8'h00);
        expect_val("reset_ready", 8'(req_ready_o), 8'h00);
        expect_val("reset_grant", 8'(grant_o),     8'h00);
        expect_val("reset_busy",  8'(busy_o),      8'h00);
        adv();

        // Single producer, same-cycle acceptance
        rst = 1'b0; valid = 3'b010; data = {8'h33, 8'hA5, 8'h11}; size = '0;
        probe("t1");
        expect_val("t1_ready", 8'(req_ready_o), 8'h02);
        expect_val("t1_set",   8'(fifo_set_o),  8'h01);
        expect_val("t1_data",  fifo_data_o,     8'hA5);
        adv();
        valid = 3'b111;
        probe("t1_next");
`ifdef FIFO_WR_ARBITER_LOCK_EN
        expect_val("t1_next_grant", 8'(grant_o), 8'h02);
`else
        expect_val("t1_next_grant", 8'(grant_o), 8'h04);
`endif
        adv();

        // All requesters valid continuously
        rst = 1'b1; step("t3_rst"); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            data = 24'($urandom);
            probe("t3");
            expect_val("t3_set", 8'(fifo_set_o), 8'h01);
`ifdef FIFO_WR_ARBITER_LOCK_EN
            expect_val("t3_grant", 8'(grant_o), 8'(3'b001 << (i / 4)));
            expect_val("t3_busy",  8'(busy_o),  8'((i % 4) != 0));
`else
            expect_val("t3_grant", 8'(grant_o), 8'(3'b001 << (i % 3)));
            expect_val("t3_busy",  8'(busy_o),  8'h00);
`endif
            adv();
        end

        // Full stall mid-burst, then resume
        rst = 1'b1; step("t4_rst"); rst = 1'b0; size = '0;
        step("t4_fill0"); step("t4_fill1");
        size = 7'd7;
        for (int i = 0; i < 3; i++) begin
            probe("t4_full");
            expect_val("t4_full_set",   8'(fifo_set_o),  8'h00);
            expect_val("t4_full_ready", 8'(req_ready_o), 8'h00);
            adv();
        end
        size = 7'd6;
        for (int i = 0; i < 2; i++) begin
            probe("t4_resume");
            expect_val("t4_resume_set", 8'(fifo_set_o), 8'h01);
            adv();
        end
        step("t4_after");
        size = '0;

        // Owner drops valid mid-burst
        rst = 1'b1; step("t5_rst"); rst = 1'b0;
        step("t5_w0"); step("t5_w1");
        valid = 3'b110;
        probe("t5_drop");
`ifdef FIFO_WR_ARBITER_LOCK_EN
        expect_val("t5_bubble_set", 8'(fifo_set_o), 8'h00);
        adv();
        probe("t5_regrant");
        expect_val("t5_regrant_grant", 8'(grant_o), 8'h02);
`endif
        adv();

        // Reset mid-burst
        valid = 3'b111;
        rst = 1'b1; step("t6_rst"); rst = 1'b0;
        step("t6_w0"); step("t6_w1");
        rst = 1'b1;
        probe("t6_midrst");
        expect_val("t6_midrst_set", 8'(fifo_set_o), 8'h00);
        adv();
        rst = 1'b0;
        probe("t6_after");
        expect_val("t6_after_grant", 8'(grant_o), 8'h01);
        adv();
        step("t6_cont0"); step("t6_cont1");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 39) == 0);
            valid = 3'($urandom);
            data  = 24'($urandom);
            size  = ($urandom_range(0, 3) == 0) ? 7'd7 : 7'($urandom_range(0, 6));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
